// File: rtl/mag_window_stats.sv
// Windowed mean/max/min of an unsigned magnitude stream over N = 2**LOG2_WIN samples.
// Optional min tracking: define MAG_WINDOW_STATS_MIN_EN (otherwise min_o is tied to 0).
module mag_window_stats #(
  parameter int WIDTH    = 32,
  parameter int LOG2_WIN = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             clear_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] mean_o,
  output logic [WIDTH-1:0] max_o,
  output logic [WIDTH-1:0] min_o,
  output logic             overflow_o
);

  localparam int SW = WIDTH + LOG2_WIN;
  localparam logic [LOG2_WIN-1:0] CNT_LAST = '1;

  logic [LOG2_WIN-1:0] cnt_q, cnt_d;
  logic [SW-1:0]       sum_q, sum_d;
  logic [WIDTH-1:0]    max_q, max_d;
  logic [WIDTH-1:0]    mean_out_q, mean_out_d;
  logic [WIDTH-1:0]    max_out_q, max_out_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;

  logic                first, last, take, done, load;
  logic [SW-1:0]       acc_sum;
  logic [WIDTH-1:0]    acc_max;

`ifdef MAG_WINDOW_STATS_MIN_EN
  logic [WIDTH-1:0]    min_q, min_d;
  logic [WIDTH-1:0]    min_out_q, min_out_d;
  logic [WIDTH-1:0]    acc_min;
`endif

  always_comb begin
    first   = (cnt_q == '0);
    last    = (cnt_q == CNT_LAST);
    take    = valid_i && !clear_i;
    done    = take && last;
    load    = done && (!valid_q || ready_i);
    acc_sum = first ? SW'(data_i) : sum_q + SW'(data_i);
    acc_max = (first || data_i > max_q) ? data_i : max_q;

    cnt_d      = cnt_q;
    sum_d      = sum_q;
    max_d      = max_q;
    mean_out_d = mean_out_q;
    max_out_d  = max_out_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
`ifdef MAG_WINDOW_STATS_MIN_EN
    acc_min    = (first || data_i < min_q) ? data_i : min_q;
    min_d      = min_q;
    min_out_d  = min_out_q;
`endif

    if (clear_i || done) begin
      cnt_d = '0;
      sum_d = '0;
      max_d = '0;
`ifdef MAG_WINDOW_STATS_MIN_EN
      min_d = '0;
`endif
    end else if (take) begin
      cnt_d = cnt_q + LOG2_WIN'(1);
      sum_d = acc_sum;
      max_d = acc_max;
`ifdef MAG_WINDOW_STATS_MIN_EN
      min_d = acc_min;
`endif
    end

    // A completing window either replaces an accepted/empty result or is dropped.
    if (load) begin
      mean_out_d = acc_sum[SW-1:LOG2_WIN];
      max_out_d  = acc_max;
      valid_d    = 1'b1;
`ifdef MAG_WINDOW_STATS_MIN_EN
      min_out_d  = acc_min;
`endif
    end else if (done) begin
      ovf_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      sum_q      <= '0;
      max_q      <= '0;
      mean_out_q <= '0;
      max_out_q  <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef MAG_WINDOW_STATS_MIN_EN
      min_q      <= '0;
      min_out_q  <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      mean_out_q <= mean_out_d;
      max_out_q  <= max_out_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
`ifdef MAG_WINDOW_STATS_MIN_EN
      min_q      <= min_d;
      min_out_q  <= min_out_d;
`endif
    end
  end

  assign valid_o    = valid_q;
  assign mean_o     = mean_out_q;
  assign max_o      = max_out_q;
  assign overflow_o = ovf_q;
`ifdef MAG_WINDOW_STATS_MIN_EN
  assign min_o      = min_out_q;
`else
  assign min_o      = '0;
`endif

endmodule

// File: tb/tb_mag_window_stats.sv
// Directed bench for mag_window_stats (WIDTH=32, N=4); expected min is 0 when
// MAG_WINDOW_STATS_MIN_EN is not defined.
module tb_mag_window_stats;

  logic        clk = 1'b0;
  logic        rst_i, valid_i, clear_i, ready_i;
  logic [31:0] data_i;
  logic        valid_o, overflow_o;
  logic [31:0] mean_o, max_o, min_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mag_window_stats #(.WIDTH(32), .LOG2_WIN(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i),
    .clear_i(clear_i), .valid_o(valid_o), .ready_i(ready_i),
    .mean_o(mean_o), .max_o(max_o), .min_o(min_o), .overflow_o(overflow_o)
  );

  typedef struct {
    logic [31:0] d [4];
    int          gap;
    logic [31:0] mean;
    logic [31:0] mx;
    logic [31:0] mn;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [31:0] emin(input logic [31:0] v);
`ifdef MAG_WINDOW_STATS_MIN_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one sample for one cycle, then idle for gap cycles.
  task automatic send(input logic [31:0] d, input int gap, input logic clr);
    valid_i = 1'b1;
    data_i  = d;
    clear_i = clr;
    @(negedge clk);
    valid_i = 1'b0;
    clear_i = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic chk_result(input string name, input logic [31:0] m,
                            input logic [31:0] mx, input logic [31:0] mn);
    chk({name, ".valid"}, 32'(valid_o), 32'd1);
    chk({name, ".mean"}, mean_o, m);
    chk({name, ".max"}, max_o, mx);
    chk({name, ".min"}, min_o, emin(mn));
  endtask

  initial begin
    vecs[0] = '{d: '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000}, gap: 0,
                mean: 32'h0002_8000, mx: 32'h0004_0000, mn: 32'h0001_0000};
    vecs[1] = '{d: '{32'd1, 32'd2, 32'd2, 32'd2}, gap: 2, mean: 32'd1, mx: 32'd2, mn: 32'd1};
    vecs[2] = '{d: '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, gap: 0,
                mean: 32'hFFFF_FFFF, mx: 32'hFFFF_FFFF, mn: 32'hFFFF_FFFF};
    vecs[3] = '{d: '{32'd7, 32'd3, 32'd9, 32'd1}, gap: 1, mean: 32'd5, mx: 32'd9, mn: 32'd1};
    vecs[4] = '{d: '{32'd0, 32'd0, 32'd0, 32'd5}, gap: 0, mean: 32'd1, mx: 32'd5, mn: 32'd0};

    rst_i = 1'b1; valid_i = 1'b0; clear_i = 1'b0; ready_i = 1'b1; data_i = '0;
    repeat (3) @(negedge clk);
    chk("rst.valid", 32'(valid_o), 32'd0);
    chk("rst.ovf", 32'(overflow_o), 32'd0);
    chk("rst.mean", mean_o, 32'd0);
    chk("rst.max", max_o, 32'd0);
    chk("rst.min", min_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) send(vecs[i].d[j], (j == 3) ? 0 : vecs[i].gap, 1'b0);
      chk_result($sformatf("vec%0d", i), vecs[i].mean, vecs[i].mx, vecs[i].mn);
      @(negedge clk);
      chk($sformatf("vec%0d.drop", i), 32'(valid_o), 32'd0);
      chk($sformatf("vec%0d.hold", i), mean_o, vecs[i].mean);
    end

    // Acceptance and a new completion in the same cycle: new result loads.
    ready_i = 1'b0;
    for (int j = 0; j < 4; j++) send(32'd2, 0, 1'b0);
    chk_result("b2b.a", 32'd2, 32'd2, 32'd2);
    for (int j = 0; j < 3; j++) send(32'd3 + 32'(j), 0, 1'b0);
    chk_result("b2b.hold", 32'd2, 32'd2, 32'd2);
    ready_i = 1'b1;
    send(32'd6, 0, 1'b0);
    chk_result("b2b.b", 32'd4, 32'd6, 32'd3);
    chk("b2b.ovf", 32'(overflow_o), 32'd0);
    @(negedge clk);
    chk("b2b.drop", 32'(valid_o), 32'd0);

    // Result dropped while stalled sets sticky overflow.
    ready_i = 1'b0;
    for (int j = 0; j < 4; j++) send(32'd5, 0, 1'b0);
    chk_result("ovf.first", 32'd5, 32'd5, 32'd5);
    chk("ovf.pre", 32'(overflow_o), 32'd0);
    for (int j = 0; j < 4; j++) send(32'd9, 1, 1'b0);
    chk_result("ovf.kept", 32'd5, 32'd5, 32'd5);
    chk("ovf.set", 32'(overflow_o), 32'd1);
    ready_i = 1'b1;
    @(negedge clk);
    chk("ovf.drop", 32'(valid_o), 32'd0);
    chk("ovf.sticky", 32'(overflow_o), 32'd1);
    chk("ovf.hold", mean_o, 32'd5);

    // clear_i aborts the partial window and swallows the coincident sample.
    send(32'd100, 0, 1'b0);
    send(32'd100, 0, 1'b0);
    send(32'd7, 0, 1'b1);
    chk("clr.novalid", 32'(valid_o), 32'd0);
    for (int j = 0; j < 3; j++) send(32'd8, 0, 1'b0);
    chk("clr.early", 32'(valid_o), 32'd0);
    send(32'd8, 0, 1'b0);
    chk_result("clr", 32'd8, 32'd8, 32'd8);
    @(negedge clk);

    // Reset with a pending result and a partial window.
    ready_i = 1'b0;
    for (int j = 0; j < 4; j++) send(32'd6, 0, 1'b0);
    for (int j = 0; j < 3; j++) send(32'd50, 0, 1'b0);
    chk("rst2.pend", 32'(valid_o), 32'd1);
    rst_i = 1'b1; valid_i = 1'b1; data_i = 32'd99;
    @(negedge clk);
    rst_i = 1'b0; valid_i = 1'b0;
    chk("rst2.valid", 32'(valid_o), 32'd0);
    chk("rst2.ovf", 32'(overflow_o), 32'd0);
    chk("rst2.mean", mean_o, 32'd0);
    chk("rst2.max", max_o, 32'd0);
    chk("rst2.min", min_o, 32'd0);
    ready_i = 1'b1;
    for (int j = 0; j < 3; j++) send(32'd4, 0, 1'b0);
    chk("rst2.early", 32'(valid_o), 32'd0);
    send(32'd4, 0, 1'b0);
    chk_result("rst2", 32'd4, 32'd4, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
